// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - FSM state, grant encoding and out-of-range read pattern for mem_responder
package mem_responder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IMEM = 1'b0,
        GNT_DMEM = 1'b1
    } gnt_e;

    localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/simple_processor_pkg.sv
// rtl/simple_processor_pkg.sv - processor-wide bus widths shared by memory-side blocks
package simple_processor_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - instruction + data port bundle between a core and mem_responder
//   imem_req_i/imem_addr_i -> responder, imem_rdata_o/imem_ack_o <- responder (read only)
//   dmem_req_i/dmem_we_i/dmem_addr_i/dmem_wdata_i -> responder, dmem_rdata_o/dmem_ack_o <- responder
//   modport slave: the responder side; modport master: the requester side
interface mem_responder_if;
    import simple_processor_pkg::*;

    logic                  imem_req_i;
    logic [ADDR_WIDTH-1:0] imem_addr_i;
    logic [DATA_WIDTH-1:0] imem_rdata_o;
    logic                  imem_ack_o;

    logic                  dmem_req_i;
    logic                  dmem_we_i;
    logic [ADDR_WIDTH-1:0] dmem_addr_i;
    logic [DATA_WIDTH-1:0] dmem_wdata_i;
    logic [DATA_WIDTH-1:0] dmem_rdata_o;
    logic                  dmem_ack_o;

    modport slave (
        input  imem_req_i, imem_addr_i,
        output imem_rdata_o, imem_ack_o,
        input  dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        output dmem_rdata_o, dmem_ack_o
    );

    modport master (
        output imem_req_i, imem_addr_i,
        input  imem_rdata_o, imem_ack_o,
        output dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        input  dmem_rdata_o, dmem_ack_o
    );
endinterface

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - word storage: one synchronous write port, one asynchronous read port
//   clk_i   : write clock
//   we_i    : write enable, waddr_i/wdata_i captured on the rising edge
//   raddr_i : read index, rdata_o follows combinationally
// Contents are deliberately not reset so they survive a responder reset.
module mem_responder_array #(
    parameter int DEPTH = 4096,
    parameter int DW    = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];
endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - shared-memory responder for an instruction and a data port with fixed wait states
//   clk_i  : clock, all state on rising edge
//   arst_i : asynchronous active-high reset
//   bus    : mem_responder_if.slave (imem read port, dmem read/write port)
//   err_o  : out-of-range flag, only present when MEM_RESPONDER_OOR_CHECK_EN is defined
// Optional feature macro: MEM_RESPONDER_OOR_CHECK_EN (range check instead of index wrap).
module mem_responder
    import simple_processor_pkg::*;
    import mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH   = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             arst_i,
    mem_responder_if.slave   bus
`ifdef MEM_RESPONDER_OOR_CHECK_EN
    ,
    output logic             err_o
`endif
);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int WORD_W = ADDR_WIDTH - 2;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    gnt_e                  r_last_gnt;
    gnt_e                  r_gnt;
    gnt_e                  w_gnt;
    logic                  w_accept;
    logic                  r_we;
    logic [WORD_W-1:0]     r_word;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  w_ack;
    logic                  w_oor;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_arr_we;
    logic [DATA_WIDTH-1:0] w_arr_rdata;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^{bus.imem_addr_i[1:0], bus.dmem_addr_i[1:0]};

    // dmem has priority, but a dmem grant followed by a contended cycle yields to imem
    // so a busy data port cannot starve instruction fetch.
    always_comb begin
        w_gnt = GNT_IMEM;
        if (bus.dmem_req_i && bus.imem_req_i) begin
            w_gnt = (r_last_gnt == GNT_DMEM) ? GNT_IMEM : GNT_DMEM;
        end else if (bus.dmem_req_i) begin
            w_gnt = GNT_DMEM;
        end
    end

    assign w_accept = (r_state == ST_IDLE) && (bus.imem_req_i || bus.dmem_req_i);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter is loaded with WAIT_CYCLES on accept; ACK is entered on the edge where it reaches zero,
    // which places ack exactly WAIT_CYCLES edges after the accept edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = 4'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Request fields are captured once at accept; the requester may keep them stable anyway,
    // but the loser's signals must not leak into the winner's transaction.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_last_gnt <= GNT_IMEM;
            r_gnt      <= GNT_IMEM;
            r_we       <= 1'b0;
            r_word     <= '0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_last_gnt <= w_gnt;
            r_gnt      <= w_gnt;
            r_we       <= (w_gnt == GNT_DMEM) && bus.dmem_we_i;
            r_word     <= (w_gnt == GNT_DMEM) ? bus.dmem_addr_i[ADDR_WIDTH-1:2]
                                              : bus.imem_addr_i[ADDR_WIDTH-1:2];
            r_wdata    <= bus.dmem_wdata_i;
        end
    end

`ifdef MEM_RESPONDER_OOR_CHECK_EN
    assign w_oor = (r_word >= WORD_W'(MEM_DEPTH));
    assign w_idx = r_word[IDX_W-1:0];
`else
    logic [WORD_W-1:0] w_word_mod;
    logic              w_unused_mod_hi;
    assign w_oor           = 1'b0;
    assign w_word_mod      = r_word % WORD_W'(MEM_DEPTH);
    assign w_idx           = w_word_mod[IDX_W-1:0];
    assign w_unused_mod_hi = ^w_word_mod[WORD_W-1:IDX_W];
`endif

    assign w_ack = (r_state == ST_ACK);

    // The write lands on the edge closing the ack cycle, so the ack-cycle rdata shows the old word.
    assign w_arr_we = w_ack && r_we && !w_oor;

    mem_responder_array #(
        .DEPTH (MEM_DEPTH),
        .DW    (DATA_WIDTH),
        .AW    (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (w_arr_we),
        .waddr_i (w_idx),
        .wdata_i (r_wdata),
        .raddr_i (w_idx),
        .rdata_o (w_arr_rdata)
    );

    assign w_rdata = w_oor ? DATA_WIDTH'(OOR_RDATA) : w_arr_rdata;

    assign bus.imem_ack_o   = w_ack && (r_gnt == GNT_IMEM);
    assign bus.dmem_ack_o   = w_ack && (r_gnt == GNT_DMEM);
    assign bus.imem_rdata_o = bus.imem_ack_o ? w_rdata : '0;
    assign bus.dmem_rdata_o = bus.dmem_ack_o ? w_rdata : '0;

`ifdef MEM_RESPONDER_OOR_CHECK_EN
    assign err_o = w_ack && w_oor;
`endif
endmodule
